r16_outpipe_ser: RTL and testbench
==================================

# r16_outpipe_ser

Output-side pipeline buffer and serializer for the radix-16 16384-point FFT datapath. It accepts one 16-sample result group per cycle from the last FFT stage: bank B0 carries samples D0..D7 and bank B1 carries samples D0..D7. It buffers up to two groups and emits each group as two 8-sample beats, B0 first and then B1, on a valid/ready interface. It also marks frame boundaries and flags overflow, because the FFT core cannot be stalled.

## Interface
- CP_WIDTH, 22: width of one complex sample word.
- GRP_PER_FRAME, 1024: groups per FFT frame (16384/16). Must be a power of two, ≥2.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- fft_valid_in  in  1  a result group is present on the b0/b1 inputs this cycle.
- b0_dk_in (k=0..7)  in  CP_WIDTH each  bank-0 samples of the group.
- b1_dk_in (k=0..7)  in  CP_WIDTH each  bank-1 samples of the group.
- in_ready  out  1  buffer can accept a group this cycle (advisory only to the core).
- ovf_err  out  1  sticky: a group arrived while the buffer was full.
- out_valid  out  1  out_dk holds a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_dk (k=0..7)  out  CP_WIDTH each  beat samples.
- out_bank  out  1  0 = B0 half, 1 = B1 half.
- out_sof  out  1  first beat (B0) of group 0 of a frame.
- out_eof  out  1  last beat (B1) of group GRP_PER_FRAME-1.

## Operation
- Storage: 2-entry group FIFO (16×CP_WIDTH per entry), write pointer, read pointer, and a 2-bit count.
- Write: when fft_valid_in && count<2, the group is stored at wptr and wptr toggles.
- Drop: when fft_valid_in && count==2, the group is discarded, ovf_err is set, and the group counter does not advance. ovf_err clears only on reset.
- in_ready = (count<2), combinational. There is no same-cycle pop bypass: a full buffer refuses the group even if it frees an entry in that cycle.
- FSM states:
  - IDLE (count==0): out_valid=0.
  - SEND0: presents B0 of entry rptr, out_bank=0.
  - SEND1: presents B1 of entry rptr, out_bank=1.
- FSM transitions:
  - IDLE→SEND0 when count becomes nonzero.
  - SEND0→SEND1 on handshake (out_valid && out_ready).
  - SEND1 on handshake: the entry is freed, rptr toggles, and the FSM goes to SEND0 if another entry remains, otherwise IDLE.
  - No handshake: state and all outputs hold.
- Simultaneous write and pop: count is unchanged, both pointers advance, and the written group is retained.
- out_dk is muxed from the flopped entry by rptr/bank. It is stable while out_valid && !out_ready.
- Group counter grp_cnt (log2(GRP_PER_FRAME) bits) tracks the head group. It increments on each SEND1 handshake and wraps from GRP_PER_FRAME-1 to 0.
- out_sof = SEND0 && grp_cnt==0.
- out_eof = SEND1 && grp_cnt==GRP_PER_FRAME-1.
- Reset mid-operation: both FIFO entries are lost, all pointers and counters clear, and the FSM returns to IDLE immediately.

## Timing
- Reset values: out_valid 0, out_dk 0, out_bank 0, out_sof 0, out_eof 0, ovf_err 0, in_ready 1 (count 0). Storage clears to 0.
- Latency: a group accepted at edge t gives out_valid=1 with B0 in cycle t+1. With out_ready held at 1, B1 follows in cycle t+2.
- Throughput: one group per 2 cycles sustained. Back-to-back input at 1 group/cycle overflows on the 3rd consecutive group if out_ready is held at 1.
- ovf_err rises the cycle after the dropped group's edge.
- out_valid never drops without a handshake.

## Structure
- Shared package r16_pkg: CP_WIDTH, the 16384-point / 16-lane constants, the sample word typedef, the 8-sample bank array typedef, the 16-sample group typedef, and the FSM state enum (IDLE/SEND0/SEND1).
- One natural sub-module, r16_grp_fifo2: the 2-entry group storage with pointers and count. The FSM, the mux, and the frame counter stay in the top.

## Test plan
- Reset, then one group (B0 Dk = 0x100+k, B1 Dk = 0x200+k), out_ready=1 → B0 beat at t+1 with out_sof=1, B1 beat at t+2, then out_valid=0.
- out_ready=0 for 5 cycles after a group → B0 beat held unchanged, out_bank=0 for all 5 cycles; B0 transfers in the first cycle out_ready=1.
- 3 groups on consecutive cycles, out_ready=0 → in_ready=0 after the 2nd, 3rd group dropped, ovf_err=1. Releasing out_ready yields exactly 4 beats of groups 1 and 2.
- Write in the same cycle as the SEND1 handshake with count=1 → count stays 1 and the next group's B0 appears on the following cycle without an IDLE gap.
- 2×GRP_PER_FRAME groups, random out_ready → out_eof on beats 2047 and 4095, out_sof on beats 0 and 2048, data in order, no drops.
- rst_n asserted while 2 entries are pending and the FSM is in SEND1 → all outputs 0 asynchronously and in_ready=1. After release, the first new group's B0 appears with out_sof=1.

Source files
------------

// File: rtl/r16_pkg.sv
// Shared constants and types for the radix-16 16384-point FFT output path.
package r16_pkg;

  localparam int unsigned CP_WIDTH     = 22;
  localparam int unsigned FFT_POINTS   = 16384;
  localparam int unsigned LANES        = 16;
  localparam int unsigned BANK_LANES   = LANES / 2;
  localparam int unsigned FRAME_GROUPS = FFT_POINTS / LANES;

  typedef logic [CP_WIDTH-1:0]       cp_word_t;
  typedef cp_word_t [BANK_LANES-1:0] bank_t;
  typedef bank_t [1:0]               grp_t;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_e;

endpackage

// File: rtl/r16_grp_fifo2.sv
// Two-entry result-group FIFO; a full FIFO refuses a push even when it pops in the same cycle.
module r16_grp_fifo2 #(
  parameter int unsigned Width = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [16*Width-1:0] wrData_i,
  output logic [16*Width-1:0] rdData_o,
  output logic [1:0]          count_o,
  output logic                full_o,
  output logic                wrAccept_o
);

  logic [1:0][16*Width-1:0] memQ;
  logic                     wptrQ;
  logic                     rptrQ;
  logic [1:0]               cntQ;
  logic [1:0]               cntD;

  assign full_o     = (cntQ == 2'd2);
  assign wrAccept_o = push_i && !full_o;
  assign count_o    = cntQ;
  assign rdData_o   = memQ[rptrQ];

  always_comb begin
    cntD = cntQ;
    unique case ({wrAccept_o, pop_i})
      2'b10:   cntD = cntQ + 2'd1;
      2'b01:   cntD = cntQ - 2'd1;
      default: cntD = cntQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memQ  <= '0;
      wptrQ <= 1'b0;
      rptrQ <= 1'b0;
      cntQ  <= 2'd0;
    end else begin
      if (wrAccept_o) begin
        memQ[wptrQ] <= wrData_i;
        wptrQ       <= ~wptrQ;
      end
      if (pop_i) begin
        rptrQ <= ~rptrQ;
      end
      cntQ <= cntD;
    end
  end

endmodule

// File: rtl/r16_outpipe_ser.sv
// Output buffer and serializer: each 16-sample group leaves as a B0 beat then a B1 beat,
// with frame start/end marks and a sticky overflow flag since the FFT core cannot stall.
module r16_outpipe_ser import r16_pkg::*; #(
  parameter int unsigned CP_WIDTH      = r16_pkg::CP_WIDTH,
  parameter int unsigned GRP_PER_FRAME = r16_pkg::FRAME_GROUPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fft_valid_in,
  input  logic [CP_WIDTH-1:0] b0_d0_in,
  input  logic [CP_WIDTH-1:0] b0_d1_in,
  input  logic [CP_WIDTH-1:0] b0_d2_in,
  input  logic [CP_WIDTH-1:0] b0_d3_in,
  input  logic [CP_WIDTH-1:0] b0_d4_in,
  input  logic [CP_WIDTH-1:0] b0_d5_in,
  input  logic [CP_WIDTH-1:0] b0_d6_in,
  input  logic [CP_WIDTH-1:0] b0_d7_in,
  input  logic [CP_WIDTH-1:0] b1_d0_in,
  input  logic [CP_WIDTH-1:0] b1_d1_in,
  input  logic [CP_WIDTH-1:0] b1_d2_in,
  input  logic [CP_WIDTH-1:0] b1_d3_in,
  input  logic [CP_WIDTH-1:0] b1_d4_in,
  input  logic [CP_WIDTH-1:0] b1_d5_in,
  input  logic [CP_WIDTH-1:0] b1_d6_in,
  input  logic [CP_WIDTH-1:0] b1_d7_in,
  output logic                in_ready,
  output logic                ovf_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CP_WIDTH-1:0] out_d0,
  output logic [CP_WIDTH-1:0] out_d1,
  output logic [CP_WIDTH-1:0] out_d2,
  output logic [CP_WIDTH-1:0] out_d3,
  output logic [CP_WIDTH-1:0] out_d4,
  output logic [CP_WIDTH-1:0] out_d5,
  output logic [CP_WIDTH-1:0] out_d6,
  output logic [CP_WIDTH-1:0] out_d7,
  output logic                out_bank,
  output logic                out_sof,
  output logic                out_eof
);

  localparam int unsigned GrpW    = $clog2(GRP_PER_FRAME);
  localparam int unsigned BankW   = 8 * CP_WIDTH;
  localparam int unsigned GrpBits = 16 * CP_WIDTH;
  localparam logic [GrpW-1:0] LastGrp = GrpW'(GRP_PER_FRAME - 1);

  logic [GrpBits-1:0] wrData;
  logic [GrpBits-1:0] rdData;
  logic [BankW-1:0]   beat;
  logic [1:0]         count;
  logic               full;
  logic               wrAccept;
  logic               pop;
  logic               ovfQ;
  logic [GrpW-1:0]    grpCntQ;
  state_e             stateQ;
  state_e             stateD;

  // B0 occupies the low half of a stored entry, B1 the high half.
  assign wrData = {b1_d7_in, b1_d6_in, b1_d5_in, b1_d4_in, b1_d3_in, b1_d2_in, b1_d1_in, b1_d0_in,
                   b0_d7_in, b0_d6_in, b0_d5_in, b0_d4_in, b0_d3_in, b0_d2_in, b0_d1_in, b0_d0_in};

  r16_grp_fifo2 #(
    .Width (CP_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fft_valid_in),
    .pop_i      (pop),
    .wrData_i   (wrData),
    .rdData_o   (rdData),
    .count_o    (count),
    .full_o     (full),
    .wrAccept_o (wrAccept)
  );

  assign out_valid = (stateQ != IDLE);
  assign out_bank  = (stateQ == SEND1);
  assign pop       = (stateQ == SEND1) && out_ready;
  assign in_ready  = !full;
  assign ovf_err   = ovfQ;
  assign out_sof   = (stateQ == SEND0) && (grpCntQ == '0);
  assign out_eof   = (stateQ == SEND1) && (grpCntQ == LastGrp);

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (wrAccept) stateD = SEND0;
      SEND0:   if (out_ready) stateD = SEND1;
      // Another entry remains if the FIFO was full or a group lands on this same edge.
      SEND1:   if (out_ready) stateD = ((count == 2'd2) || wrAccept) ? SEND0 : IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      grpCntQ <= '0;
      ovfQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (pop) begin
        grpCntQ <= grpCntQ + GrpW'(1);
      end
      if (fft_valid_in && full) begin
        ovfQ <= 1'b1;
      end
    end
  end

  assign beat   = out_bank ? rdData[GrpBits-1 -: BankW] : rdData[BankW-1:0];
  assign out_d0 = beat[0*CP_WIDTH +: CP_WIDTH];
  assign out_d1 = beat[1*CP_WIDTH +: CP_WIDTH];
  assign out_d2 = beat[2*CP_WIDTH +: CP_WIDTH];
  assign out_d3 = beat[3*CP_WIDTH +: CP_WIDTH];
  assign out_d4 = beat[4*CP_WIDTH +: CP_WIDTH];
  assign out_d5 = beat[5*CP_WIDTH +: CP_WIDTH];
  assign out_d6 = beat[6*CP_WIDTH +: CP_WIDTH];
  assign out_d7 = beat[7*CP_WIDTH +: CP_WIDTH];

endmodule

// File: tb/tb_r16_outpipe_ser.sv
// Scoreboard bench for r16_outpipe_ser: stimulus pushes expected beats, a negedge monitor pops them.
module tb_r16_outpipe_ser;

  localparam int W   = 22;
  localparam int GPF = 1024;

  typedef logic [7:0][W-1:0] bank8_t;
  typedef struct packed {
    bank8_t d;
    logic   bank;
    logic   sof;
    logic   eof;
  } beat_t;

  logic   clk;
  logic   rst_n;
  logic   fft_valid_in;
  bank8_t b0In;
  bank8_t b1In;
  logic   in_ready;
  logic   ovf_err;
  logic   out_valid;
  logic   out_ready;
  bank8_t outVec;
  logic   out_bank;
  logic   out_sof;
  logic   out_eof;

  beat_t sb[$];
  beat_t eBeat;
  int    nVec = 0;
  int    nErr = 0;
  int    grpIdx = 0;
  int    beatCnt = 0;

  r16_outpipe_ser #(
    .CP_WIDTH      (W),
    .GRP_PER_FRAME (GPF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fft_valid_in (fft_valid_in),
    .b0_d0_in     (b0In[0]),
    .b0_d1_in     (b0In[1]),
    .b0_d2_in     (b0In[2]),
    .b0_d3_in     (b0In[3]),
    .b0_d4_in     (b0In[4]),
    .b0_d5_in     (b0In[5]),
    .b0_d6_in     (b0In[6]),
    .b0_d7_in     (b0In[7]),
    .b1_d0_in     (b1In[0]),
    .b1_d1_in     (b1In[1]),
    .b1_d2_in     (b1In[2]),
    .b1_d3_in     (b1In[3]),
    .b1_d4_in     (b1In[4]),
    .b1_d5_in     (b1In[5]),
    .b1_d6_in     (b1In[6]),
    .b1_d7_in     (b1In[7]),
    .in_ready     (in_ready),
    .ovf_err      (ovf_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_d0       (outVec[0]),
    .out_d1       (outVec[1]),
    .out_d2       (outVec[2]),
    .out_d3       (outVec[3]),
    .out_d4       (outVec[4]),
    .out_d5       (outVec[5]),
    .out_d6       (outVec[6]),
    .out_d7       (outVec[7]),
    .out_bank     (out_bank),
    .out_sof      (out_sof),
    .out_eof      (out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    nVec++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample k of group g is g*32 + off + k, so g=8/16 give the 0x100+k / 0x200+k pattern.
  function automatic bank8_t mkGrp(input int g, input int off);
    bank8_t r;
    for (int k = 0; k < 8; k++) r[k] = W'(g * 32 + off + k);
    return r;
  endfunction

  task automatic sendGroup(input bank8_t b0, input bank8_t b1, input bit accept);
    beat_t e0;
    beat_t e1;
    fft_valid_in = 1'b1;
    b0In = b0;
    b1In = b1;
    if (accept) begin
      e0.d = b0; e0.bank = 1'b0; e0.sof = (grpIdx % GPF == 0);       e0.eof = 1'b0;
      e1.d = b1; e1.bank = 1'b1; e1.sof = 1'b0; e1.eof = (grpIdx % GPF == GPF - 1);
      sb.push_back(e0);
      sb.push_back(e1);
      grpIdx++;
    end
    tick();
    fft_valid_in = 1'b0;
  endtask

  task automatic waitDrain(input string nm);
    for (int i = 0; i < 500 && sb.size() != 0; i++) tick();
    chk(nm, 256'(sb.size()), 256'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      nVec++;
      if (sb.size() == 0) begin
        nErr++;
        $display("FAIL unexpected_beat: got bank %0b data %0h want no beat", out_bank, outVec);
      end else begin
        eBeat = sb.pop_front();
        if ({outVec, out_bank, out_sof, out_eof} !== eBeat) begin
          nErr++;
          $display("FAIL beat%0d: got %0h/%0b%0b%0b want %0h/%0b%0b%0b", beatCnt, outVec,
                   out_bank, out_sof, out_eof, eBeat.d, eBeat.bank, eBeat.sof, eBeat.eof);
        end
      end
      beatCnt++;
    end
  end

  initial begin
    int sent;
    int pend;
    rst_n = 1'b0;
    fft_valid_in = 1'b0;
    out_ready = 1'b0;
    b0In = '0;
    b1In = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_dk", outVec, 0);
    chk("rst_flags", {out_bank, out_sof, out_eof, ovf_err}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single group, ready held high.
    out_ready = 1'b1;
    sendGroup(mkGrp(8, 0), mkGrp(16, 0), 1);
    chk("t1_b0_valid_sof", {out_valid, out_bank, out_sof}, 3'b101);
    chk("t1_b0_data", outVec, mkGrp(8, 0));
    tick();
    chk("t1_b1_valid_bank", {out_valid, out_bank, out_sof}, 3'b110);
    chk("t1_b1_data", outVec, mkGrp(16, 0));
    tick();
    chk("t1_idle", out_valid, 0);

    // Back-pressure: B0 must hold for 5 cycles.
    out_ready = 1'b0;
    sendGroup(mkGrp(40, 0), mkGrp(40, 16), 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid_bank", {out_valid, out_bank}, 2'b10);
      chk("t2_hold_data", outVec, mkGrp(40, 0));
      tick();
    end
    out_ready = 1'b1;
    waitDrain("t2_drain");

    // Overflow: third consecutive group is dropped.
    out_ready = 1'b0;
    sendGroup(mkGrp(50, 0), mkGrp(50, 16), 1);
    chk("t3_in_ready_1grp", in_ready, 1);
    sendGroup(mkGrp(51, 0), mkGrp(51, 16), 1);
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_ovf_before", ovf_err, 0);
    sendGroup(mkGrp(52, 0), mkGrp(52, 16), 0);
    chk("t3_ovf_after", ovf_err, 1);
    chk("t3_in_ready_still_full", in_ready, 0);
    out_ready = 1'b1;
    waitDrain("t3_drain");
    tick();
    tick();
    chk("t3_no_extra_beats", out_valid, 0);
    chk("t3_ovf_sticky", ovf_err, 1);

    // Write on the same edge as the SEND1 handshake with one entry held.
    sendGroup(mkGrp(60, 0), mkGrp(60, 16), 1);
    tick();
    chk("t4_in_send1", {out_valid, out_bank}, 2'b11);
    sendGroup(mkGrp(61, 0), mkGrp(61, 16), 1);
    chk("t4_no_gap", {out_valid, out_bank}, 2'b10);
    chk("t4_next_b0", outVec, mkGrp(61, 0));
    chk("t4_count_one", in_ready, 1);
    waitDrain("t4_drain");

    // Reset while two entries are pending and the FSM is in SEND1.
    out_ready = 1'b0;
    sendGroup(mkGrp(70, 0), mkGrp(70, 16), 1);
    sendGroup(mkGrp(71, 0), mkGrp(71, 16), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_in_send1", {out_valid, out_bank, in_ready}, 3'b110);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_dk", outVec, 0);
    chk("t6_rst_flags", {out_bank, out_sof, out_eof, ovf_err}, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    sb.delete();
    grpIdx = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // Two full frames with random back-pressure; the first group checks out_sof after reset.
    beatCnt = 0;
    sent = 0;
    for (int c = 0; c < 40000 && sent < 2 * GPF; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      pend = (sb.size() + 1) / 2;
      chk("rand_in_ready", in_ready, (pend < 2));
      if (pend < 2 && $urandom_range(0, 3) != 0) begin
        sendGroup(mkGrp(sent, 0), mkGrp(sent, 16), 1);
        sent++;
      end else begin
        tick();
      end
    end
    chk("rand_groups_sent", 256'(sent), 256'(2 * GPF));
    out_ready = 1'b1;
    waitDrain("rand_drain");
    chk("rand_beat_total", 256'(beatCnt), 256'(4 * GPF));
    chk("rand_no_ovf", ovf_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
